// File: rtl/cheby_fx_eval.sv
// Fixed-point Chebyshev series evaluator using the Clenshaw recurrence, one multiply-add per clock.
// Define CHEBY_FX_SAT_EN to saturate every step and the result; otherwise two's-complement wrap.
module cheby_fx_eval #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 14,
    parameter int ORDER  = 7,
    parameter int TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [TAG_W-1:0]           out_tag,
    input  logic                       out_ready,
    input  logic                       coef_we,
    input  logic [$clog2(ORDER+1)-1:0] coef_addr,
    input  logic [DATA_W-1:0]          coef_wdata,
    output logic                       coef_ready
);

    localparam int ADDR_W = $clog2(ORDER + 1);
    localparam int SUM_W  = DATA_W + 3;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{4{1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{4{1'b1}}, {(DATA_W-1){1'b0}}};

    generate
        if (ORDER < 1) begin : g_order_check
            $error("cheby_fx_eval: ORDER must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_coef [ORDER+1];
    logic signed [DATA_W-1:0]  r_x;
    logic signed [DATA_W-1:0]  r_b1;
    logic signed [DATA_W-1:0]  r_b2;
    logic [ADDR_W-1:0]         r_k;
    logic [TAG_W-1:0]          r_tag;

    logic signed [DATA_W-1:0]  w_coef_k;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [SUM_W-1:0]   w_xb;
    logic signed [SUM_W-1:0]   w_term;
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [DATA_W-1:0]  w_res;
    logic                      w_addr_ok;
    logic                      w_idle;

    assign w_idle     = (r_state == S_IDLE);
    assign in_ready   = w_idle;
    assign coef_ready = w_idle;
    assign w_addr_ok  = ({1'b0, coef_addr} <= (ADDR_W+1)'(ORDER));

    // r_k == 0 selects the closing step c_0 + x*b1 - b2; otherwise c_k + 2*x*b1 - b2.
    assign w_coef_k = r_coef[r_k];
    assign w_prod   = r_x * r_b1;
    assign w_xb     = SUM_W'(w_prod >>> FRAC_W);
    assign w_term   = (r_k != '0) ? (w_xb <<< 1) : w_xb;
    assign w_sum    = SUM_W'(w_coef_k) + w_term - SUM_W'(r_b2);

`ifdef CHEBY_FX_SAT_EN
    assign w_res = (w_sum > SAT_MAX) ? SAT_MAX[DATA_W-1:0] :
                   (w_sum < SAT_MIN) ? SAT_MIN[DATA_W-1:0] :
                                       w_sum[DATA_W-1:0];
`else
    assign w_res = w_sum[DATA_W-1:0];
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            r_x       <= '0;
            r_b1      <= '0;
            r_b2      <= '0;
            r_k       <= '0;
            r_tag     <= '0;
            // NOTE: the coefficient table is plain registers, so clearing it on reset is legal and required.
            for (int i = 0; i <= ORDER; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            if (coef_we && w_idle && w_addr_ok) begin
                r_coef[coef_addr] <= coef_wdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_data;
                        r_tag   <= in_tag;
                        r_b1    <= '0;
                        r_b2    <= '0;
                        r_k     <= ADDR_W'(ORDER);
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_k != '0) begin
                        r_b2 <= r_b1;
                        r_b1 <= w_res;
                        r_k  <= r_k - 1'b1;
                    end else begin
                        out_data  <= w_res;
                        out_tag   <= r_tag;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cheby_fx_eval.sv
// Directed self-checking bench for cheby_fx_eval with hand-computed Chebyshev results.
// Overflow expectation follows CHEBY_FX_SAT_EN, matching the build of the design.
module tb_cheby_fx_eval;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 14;
    localparam int ORDER  = 7;
    localparam int TAG_W  = 4;
    localparam int ADDR_W = $clog2(ORDER + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_ready = 1'b1;
    logic              coef_we = 1'b0;
    logic [ADDR_W-1:0] coef_addr = '0;
    logic [DATA_W-1:0] coef_wdata = '0;
    logic              coef_ready;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    bit                mon_en = 1'b0;
    int                acc_q[$];
    logic [DATA_W-1:0] od_q[$];
    logic [TAG_W-1:0]  ot_q[$];

    cheby_fx_eval #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W),
        .ORDER (ORDER),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ready (out_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .coef_ready(coef_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes seen at the falling edge complete on the following rising edge.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
            if (out_valid && out_ready) begin
                od_q.push_back(out_data);
                ot_q.push_back(out_tag);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_coef(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        coef_we    = 1'b1;
        coef_addr  = addr;
        coef_wdata = data;
        step();
        coef_we    = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("in_ready wait", in_ready, 1);
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        check("out_valid wait", out_valid, 1);
    endtask

    // One sample with out_ready=1; optionally a coefficient write on the accepting edge.
    task automatic run_sample(input string name, input logic [DATA_W-1:0] x,
                              input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] exp,
                              input bit cw, input logic [ADDR_W-1:0] ca,
                              input logic [DATA_W-1:0] cd);
        int acc;
        in_data    = x;
        in_tag     = tag;
        in_valid   = 1'b1;
        coef_we    = cw;
        coef_addr  = ca;
        coef_wdata = cd;
        wait_ready();
        step();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        acc      = cyc;
        wait_out_valid();
        check({name, " latency"}, cyc - acc, ORDER + 1);
        check({name, " data"}, out_data, exp);
        check({name, " tag"}, out_tag, tag);
        step();
    endtask

    initial begin
        logic [DATA_W-1:0] exp_ovf;
        logic [DATA_W-1:0] xs [4];
        int acc;

`ifdef CHEBY_FX_SAT_EN
        exp_ovf = 16'h7FFF;
`else
        exp_ovf = 16'hA000;
`endif
        xs[0] = 16'h1000;
        xs[1] = 16'hF000;
        xs[2] = 16'h3FFF;
        xs[3] = 16'hC000;

        // Reset state
        step(2);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_tag", out_tag, 0);
        check("rst in_ready", in_ready, 1);
        check("rst coef_ready", coef_ready, 1);
        rst = 1'b1;
        step();

        // Constant term only
        write_coef(0, 16'h2000);
        run_sample("const", 16'h1234, 4'hA, 16'h2000, 1'b0, 0, 0);

        // Backpressure: result held, ports closed, coefficient write dropped
        out_ready = 1'b0;
        in_data   = 16'h0555;
        in_tag    = 4'h3;
        in_valid  = 1'b1;
        wait_ready();
        step();
        in_valid = 1'b0;
        wait_out_valid();
        check("bp data", out_data, 16'h2000);
        check("bp tag", out_tag, 4'h3);
        coef_we    = 1'b1;
        coef_addr  = 0;
        coef_wdata = 16'h1000;
        in_valid   = 1'b1;
        in_data    = 16'h7777;
        in_tag     = 4'h9;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp hold valid", out_valid, 1);
            check("bp hold data", out_data, 16'h2000);
            check("bp hold tag", out_tag, 4'h3);
            check("bp in_ready", in_ready, 0);
            check("bp coef_ready", coef_ready, 0);
        end
        coef_we   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp release valid", out_valid, 0);
        check("bp release in_ready", in_ready, 1);
        run_sample("bp dropped write", 16'h1234, 4'h5, 16'h2000, 1'b0, 0, 0);

        // T1 and T2 terms
        write_coef(0, 16'h0000);
        write_coef(1, 16'h4000);
        run_sample("T1", 16'h2000, 4'h1, 16'h2000, 1'b0, 0, 0);
        write_coef(1, 16'h0000);
        write_coef(2, 16'h4000);
        run_sample("T2", 16'h2000, 4'h2, 16'hE000, 1'b0, 0, 0);

        // Write on accept edge is used; product rounds toward -inf (-1 LSB)
        write_coef(2, 16'h0000);
        run_sample("same-edge floor", 16'hFFFF, 4'h6, 16'hFFFF, 1'b1, 1, 16'h0001);

        // Overflow on the final sum
        write_coef(0, 16'h7000);
        write_coef(1, 16'h4000);
        run_sample("overflow", 16'h3000, 4'h7, exp_ovf, 1'b0, 0, 0);

        // Reset in the middle of CALC
        in_data  = 16'h1234;
        in_tag   = 4'hB;
        in_valid = 1'b1;
        wait_ready();
        step();
        in_valid = 1'b0;
        step(3);
        rst = 1'b0;
        step();
        check("midrst out_valid", out_valid, 0);
        check("midrst out_data", out_data, 0);
        check("midrst in_ready", in_ready, 1);
        rst = 1'b1;
        run_sample("after reset", 16'h1234, 4'hC, 16'h0000, 1'b0, 0, 0);

        // Back-to-back with in_valid held: f(x) = x when only c1 = 1.0
        write_coef(1, 16'h4000);
        mon_en   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = xs[i];
            in_tag  = TAG_W'(i + 1);
            wait_ready();
            step();
        end
        in_valid = 1'b0;
        acc = 0;
        while (od_q.size() < 4 && acc < 100) begin
            step();
            acc++;
        end
        mon_en = 1'b0;
        check("b2b accept count", acc_q.size(), 4);
        check("b2b result count", od_q.size(), 4);
        for (int i = 1; i < acc_q.size(); i++) begin
            check("b2b accept spacing", acc_q[i] - acc_q[i-1], ORDER + 3);
        end
        for (int i = 0; i < od_q.size() && i < 4; i++) begin
            check("b2b data", od_q[i], xs[i]);
            check("b2b tag", ot_q[i], TAG_W'(i + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
